// File: rtl/psum_window_acc.sv
// Signed partial-sum window accumulator: sliding or block windows of WIN samples, one-entry valid/ready output.
// Define PSUM_ACC_SAT_EN to saturate the result to OUT_W; otherwise the result wraps to the low OUT_W bits.
module psum_window_acc #(
    parameter int DATA_W = 16,
    parameter int WIN    = 3,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] psum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  acc_out
);

    localparam int ACC_W  = DATA_W + $clog2(WIN);
    localparam int PTR_W  = $clog2(WIN);
    localparam int FILL_W = $clog2(WIN + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [DATA_W-1:0] win_buf_q [WIN];
    logic [PTR_W-1:0]         wp_q, wp_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic                     mode_q;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  acc_q, acc_d;

    logic                     flush;
    logic                     accept;
    logic                     full;
    logic                     result_load;
    logic [FILL_W-1:0]        fill_inc;
    logic signed [ACC_W-1:0]  ext_in;
    logic signed [ACC_W-1:0]  ext_old;
    logic signed [ACC_W-1:0]  result_sum;
    logic signed [OUT_W-1:0]  acc_conv;

    // A mode change behaves exactly like a clear for that cycle.
    assign flush     = clear || (mode != mode_q);
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign full      = (fill_q == FILL_W'(WIN));
    assign fill_inc  = fill_q + FILL_W'(1);
    assign ext_in    = {{(ACC_W-DATA_W){psum_in[DATA_W-1]}}, psum_in};
    assign ext_old   = {{(ACC_W-DATA_W){win_buf_q[wp_q][DATA_W-1]}}, win_buf_q[wp_q]};
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;

    always_comb begin
`ifdef PSUM_ACC_SAT_EN
        if (result_sum > SAT_MAX)      acc_conv = SAT_MAX[OUT_W-1:0];
        else if (result_sum < SAT_MIN) acc_conv = SAT_MIN[OUT_W-1:0];
        else                           acc_conv = result_sum[OUT_W-1:0];
`else
        acc_conv = result_sum[OUT_W-1:0];
`endif
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sum_d       = sum_q;
        fill_d      = fill_q;
        wp_d        = wp_q;
        result_load = 1'b0;
        result_sum  = sum_q;
        if (flush) begin
            sum_d  = '0;
            fill_d = '0;
            wp_d   = '0;
        end else if (accept) begin
            if (!mode) begin
                result_sum  = full ? (sum_q + ext_in - ext_old) : (sum_q + ext_in);
                sum_d       = result_sum;
                fill_d      = full ? fill_q : fill_inc;
                wp_d        = (wp_q == PTR_W'(WIN - 1)) ? '0 : wp_q + PTR_W'(1);
                result_load = full || (fill_inc == FILL_W'(WIN));
            end else begin
                result_sum = sum_q + ext_in;
                if (fill_inc == FILL_W'(WIN)) begin
                    result_load = 1'b1;
                    sum_d       = '0;
                    fill_d      = '0;
                    wp_d        = '0;
                end else begin
                    sum_d  = result_sum;
                    fill_d = fill_inc;
                end
            end
        end

        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (result_load) begin
            out_valid_d = 1'b1;
            acc_d       = acc_conv;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            sum_q       <= '0;
            fill_q      <= '0;
            wp_q        <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            wp_q        <= wp_d;
            mode_q      <= mode;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

    // NOTE: the sample buffer has no reset; entries are only read once fill==WIN has rewritten them.
    always_ff @(posedge clk) begin
        if (accept && !mode) win_buf_q[wp_q] <= psum_in;
    end

endmodule

// File: tb/tb_psum_window_acc.sv
// Directed self-checking bench for psum_window_acc with default parameters (DATA_W=16, WIN=3, OUT_W=16).
`timescale 1ns/1ps
module tb_psum_window_acc;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] psum_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] acc_out;

    int tests  = 0;
    int failed = 0;

    psum_window_acc dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum_in   (psum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        psum_in  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; clear = 1'b0; in_valid = 1'b0; psum_in = '0; out_ready = 1'b1;
        #12;
        rst = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || acc_out !== 16'sd0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_state: out_valid=%b acc_out=%0d in_ready=%b, required 0/0/1", out_valid, acc_out, in_ready);
        end
    endtask

    task automatic test_sliding();
        logic [15:0] vals [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        logic        exp_v [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] exp_a [5] = '{16'd0, 16'd0, 16'd6, 16'd9, 16'd12};
        for (int i = 0; i < 5; i++) begin
            send(vals[i]);
            tests++;
            if (out_valid !== exp_v[i] || (exp_v[i] && acc_out !== exp_a[i])) begin
                failed++;
                $display("FAIL sliding[%0d]: out_valid=%b acc_out=%0d, required %b/%0d", i, out_valid, acc_out, exp_v[i], exp_a[i]);
            end
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL sliding_idle: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_block();
        logic [15:0] exp_a [9] = '{16'd0, 16'd0, 16'd6, 16'd0, 16'd0, 16'd15, 16'd0, 16'd0, 16'd24};
        int results = 0;
        mode = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            send(16'(i + 1));
            if (out_valid === 1'b1) results++;
            tests++;
            if (out_valid !== (exp_a[i] != 0) || (exp_a[i] != 0 && acc_out !== exp_a[i])) begin
                failed++;
                $display("FAIL block[%0d]: out_valid=%b acc_out=%0d, required %b/%0d", i, out_valid, acc_out, exp_a[i] != 0, exp_a[i]);
            end
        end
        tests++;
        if (results != 3) begin
            failed++;
            $display("FAIL block_count: got %0d results, required 3", results);
        end
        mode = 1'b0;
        step();
    endtask

    task automatic test_back_pressure();
        do_clear();
        send(16'd1); send(16'd2); send(16'd3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        psum_in   = 16'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                failed++;
                $display("FAIL bp_in_ready[%0d]: in_ready=%b, required 0", i, in_ready);
            end
            step();
            tests++;
            if (out_valid !== 1'b1 || acc_out !== 16'sd6) begin
                failed++;
                $display("FAIL bp_hold[%0d]: out_valid=%b acc_out=%0d, required 1/6", i, out_valid, acc_out);
            end
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 16'sd9) begin
            failed++;
            $display("FAIL bp_release: out_valid=%b acc_out=%0d, required 1/9", out_valid, acc_out);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_pos;
`ifdef PSUM_ACC_SAT_EN
        exp_pos = 16'h7FFF;
`else
        exp_pos = 16'h7FFD;
`endif
        do_clear();
        send(16'h7FFF); send(16'h7FFF); send(16'h7FFF);
        tests++;
        if (out_valid !== 1'b1 || acc_out !== exp_pos) begin
            failed++;
            $display("FAIL sat_pos: out_valid=%b acc_out=%h, required 1/%h", out_valid, acc_out, exp_pos);
        end
        do_clear();
        send(16'h8000); send(16'h8000); send(16'h8000);
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 16'h8000) begin
            failed++;
            $display("FAIL sat_neg: out_valid=%b acc_out=%h, required 1/8000", out_valid, acc_out);
        end
    endtask

    task automatic check_123(input string tag);
        send(16'd1);
        send(16'd2);
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL %s_early: out_valid=%b, required 0", tag, out_valid);
        end
        send(16'd3);
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 16'sd6) begin
            failed++;
            $display("FAIL %s_first: out_valid=%b acc_out=%0d, required 1/6", tag, out_valid, acc_out);
        end
    endtask

    task automatic test_clear();
        do_clear();
        send(16'd5); send(16'd5);
        clear = 1'b1; in_valid = 1'b1; psum_in = 16'd5;
        step();
        clear = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL clear_drop: out_valid=%b, required 0", out_valid);
        end
        check_123("clear");
    endtask

    task automatic test_reset_mid();
        do_clear();
        send(16'd5); send(16'd5); send(16'd5);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || acc_out !== 16'sd0) begin
            failed++;
            $display("FAIL rst_async: out_valid=%b acc_out=%0d, required 0/0", out_valid, acc_out);
        end
        #2;
        rst = 1'b0;
        check_123("rst");
    endtask

    task automatic test_mode_flip();
        do_clear();
        send(16'd1); send(16'd1);
        mode = 1'b1; in_valid = 1'b1; psum_in = 16'd9;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL flip_drop: out_valid=%b, required 0", out_valid);
        end
        send(16'd2); send(16'd2);
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL flip_early: out_valid=%b, required 0", out_valid);
        end
        send(16'd2);
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 16'sd6) begin
            failed++;
            $display("FAIL flip_sum: out_valid=%b acc_out=%0d, required 1/6", out_valid, acc_out);
        end
        mode = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_sliding();
        test_block();
        test_back_pressure();
        test_saturation();
        test_clear();
        test_reset_mid();
        test_mode_flip();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
